unidade_controle: RTL and testbench
===================================

Name: unidade_controle

Overview:
Moore FSM that sequences the memory-game datapath, i.e. the downstream consumer of fluxo_dados status and the source of all its control strobes. It runs each round in three phases:
- replay of the stored sequence up to the current rodada;
- capture of one new jogada into RAM;
- round advance.
The game ends in exactly one of three states: win, error or timeout.

Parameters:
TIMEOUT_EN, 1, when 0 the inativo input is ignored and FIM_TIMEOUT is unreachable.

Ports:
clock  input  1  system clock, all state changes on rising edge
reset  input  1  asynchronous, active-high; forces state INICIAL immediately
iniciar  input  1  start/restart request, level-sampled
jogada_feita  input  1  one-cycle pulse: new button press
jogada_igual  input  1  registered jogada equals memory word at current address
fim_rodada  input  1  jogada address equals rodada count
fim_jogo  input  1  rodada counter at terminal value (15)
inativo  input  1  inactivity counter terminal count
zera_jogada  output  1  clear jogada/address counter
conta_jogada  output  1  increment jogada counter
zera_rodada  output  1  clear rodada counter
conta_rodada  output  1  increment rodada counter
zeraR  output  1  clear jogada register
registraR  output  1  load jogada register from botoes
zeraInativo  output  1  clear inactivity counter
contaInativo  output  1  enable inactivity counter
ramWE  output  1  RAM write enable (writes register value at current address)
pronto  output  1  game finished (any end state)
ganhou  output  1  finished by completing round 15
errou  output  1  finished by mismatch
timeout  output  1  finished by inactivity
db_estado  output  4  current state code

Behaviour:
- Outputs are a pure function of the state register (Moore), with no registered outputs.
- Reset (async, any time, including mid-round or mid-write): state goes to INICIAL. All outputs are 0 and db_estado=0x0. RAM is untouched.
- State codes and transitions. Any output not listed for a state is 0.
  - INICIAL 0x0: wait. If iniciar, go to PREPARA.
  - PREPARA 0x1: zera_jogada, zera_rodada, zeraR, zeraInativo. Go to INICIA_RODADA.
  - INICIA_RODADA 0x2: zera_jogada, zeraInativo. Go to ESPERA_JOGADA.
  - ESPERA_JOGADA 0x3: contaInativo.
    - If jogada_feita, go to REGISTRA.
    - Else if inativo and TIMEOUT_EN, go to FIM_TIMEOUT.
    - Otherwise stay.
  - REGISTRA 0x4: registraR, zeraInativo. Go to COMPARA.
  - COMPARA 0x5: checks in priority order:
    - !jogada_igual: go to FIM_ERRO.
    - !fim_rodada: go to PROXIMA_JOGADA.
    - fim_jogo: go to FIM_ACERTO.
    - otherwise: go to PROXIMA_ESCRITA.
  - PROXIMA_JOGADA 0x6: conta_jogada. Go to ESPERA_JOGADA.
  - PROXIMA_ESCRITA 0x7: conta_jogada, zeraInativo. Go to ESPERA_ESCRITA.
  - ESPERA_ESCRITA 0x8: contaInativo. Same branching and priority as ESPERA_JOGADA, with jogada_feita going to REGISTRA_ESCRITA.
  - REGISTRA_ESCRITA 0x9: registraR, zeraInativo. Go to ESCREVE.
  - ESCREVE 0xA: ramWE, asserted for exactly 1 cycle. Go to PROXIMA_RODADA.
  - PROXIMA_RODADA 0xB: conta_rodada. Go to INICIA_RODADA.
  - FIM_ACERTO 0xC: pronto, ganhou.
  - FIM_ERRO 0xD: pronto, errou.
  - FIM_TIMEOUT 0xE: pronto, timeout.
  - In all three FIM states: if iniciar, go to PREPARA; else stay.
  - Code 0xF is illegal. Go to INICIAL on the next edge with all outputs 0.
- Boundaries and timing:
  - jogada_feita and inativo in the same cycle: jogada_feita wins.
  - iniciar is ignored outside INICIAL and the FIM states.
  - iniciar held high in a FIM state restarts the game after one cycle.
  - Latency from jogada_feita to COMPARA: 2 edges.
  - Exactly one of ganhou/errou/timeout is ever high, and only together with pronto.
  - Rodada n (0-based) performs n+1 comparisons, then one write at address n+1.
  - At rodada 15 the game ends without a write. Address never wraps past 15.

Decomposition:
- Package unidade_controle_pkg holds the 4-bit state localparams (INICIAL..FIM_TIMEOUT, values above) and the width constant ESTADO_W=4. The bench decodes db_estado from it.
- Single module with three processes:
  - async-reset state register;
  - next-state logic;
  - output decode.
- No sub-module is needed.

Test Plan:
- Reset mid-game: assert reset in ESPERA_ESCRITA (0x8) -> db_estado=0x0 before the next edge, all outputs 0; iniciar=1 -> 0x1 then 0x2.
- Round 0 success: iniciar; jogada_feita with jogada_igual=1, fim_rodada=1, fim_jogo=0 -> sequence 0x3,0x4,0x5,0x7,0x8. Second pulse -> 0x9, then 0xA with ramWE=1 for one cycle, then 0xB with conta_rodada=1, then 0x2.
- Mismatch: in COMPARA with jogada_igual=0 -> 0xD, pronto=1, errou=1, ganhou=0. Stays until iniciar=1, then 0x1.
- Timeout: in 0x3, hold inativo=1 with no jogada_feita -> next state 0xE with timeout=1. Repeat with TIMEOUT_EN=0 -> stays in 0x3.
- Simultaneous: in 0x8, jogada_feita=1 and inativo=1 in the same cycle -> 0x9, never 0xE.
- Full game: drive 16 rounds of matches with fim_jogo=1 on the last -> 0xC, ganhou=1. Exactly 15 ramWE pulses and 15 conta_rodada pulses counted.

Source files
------------

// File: rtl/unidade_controle_pkg.sv
// State encoding shared by the memory-game control unit and its bench.
package unidade_controle_pkg;

    localparam int ESTADO_W = 4;

    localparam logic [ESTADO_W-1:0] INICIAL          = 4'h0;
    localparam logic [ESTADO_W-1:0] PREPARA          = 4'h1;
    localparam logic [ESTADO_W-1:0] INICIA_RODADA    = 4'h2;
    localparam logic [ESTADO_W-1:0] ESPERA_JOGADA    = 4'h3;
    localparam logic [ESTADO_W-1:0] REGISTRA         = 4'h4;
    localparam logic [ESTADO_W-1:0] COMPARA          = 4'h5;
    localparam logic [ESTADO_W-1:0] PROXIMA_JOGADA   = 4'h6;
    localparam logic [ESTADO_W-1:0] PROXIMA_ESCRITA  = 4'h7;
    localparam logic [ESTADO_W-1:0] ESPERA_ESCRITA   = 4'h8;
    localparam logic [ESTADO_W-1:0] REGISTRA_ESCRITA = 4'h9;
    localparam logic [ESTADO_W-1:0] ESCREVE          = 4'hA;
    localparam logic [ESTADO_W-1:0] PROXIMA_RODADA   = 4'hB;
    localparam logic [ESTADO_W-1:0] FIM_ACERTO       = 4'hC;
    localparam logic [ESTADO_W-1:0] FIM_ERRO         = 4'hD;
    localparam logic [ESTADO_W-1:0] FIM_TIMEOUT      = 4'hE;

endpackage

// File: rtl/unidade_controle.sv
// Moore control FSM for the memory game: replay, capture new jogada,
// advance rodada; ends in win, error or timeout.
module unidade_controle
    import unidade_controle_pkg::*;
#(
    parameter bit TIMEOUT_EN = 1'b1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                iniciar,
    input  logic                jogada_feita,
    input  logic                jogada_igual,
    input  logic                fim_rodada,
    input  logic                fim_jogo,
    input  logic                inativo,
    output logic                zera_jogada,
    output logic                conta_jogada,
    output logic                zera_rodada,
    output logic                conta_rodada,
    output logic                zeraR,
    output logic                registraR,
    output logic                zeraInativo,
    output logic                contaInativo,
    output logic                ramWE,
    output logic                pronto,
    output logic                ganhou,
    output logic                errou,
    output logic                timeout,
    output logic [ESTADO_W-1:0] db_estado
);

    logic [ESTADO_W-1:0] estado;
    logic [ESTADO_W-1:0] proximo;
    logic                expirou;

    assign expirou = inativo && TIMEOUT_EN;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            estado <= INICIAL;
        else
            estado <= proximo;
    end

    always_comb begin
        proximo = INICIAL;
        case (estado)
            INICIAL:          proximo = iniciar ? PREPARA : INICIAL;
            PREPARA:          proximo = INICIA_RODADA;
            INICIA_RODADA:    proximo = ESPERA_JOGADA;
            ESPERA_JOGADA: begin
                if (jogada_feita)
                    proximo = REGISTRA;
                else if (expirou)
                    proximo = FIM_TIMEOUT;
                else
                    proximo = ESPERA_JOGADA;
            end
            REGISTRA:         proximo = COMPARA;
            COMPARA: begin
                if (!jogada_igual)
                    proximo = FIM_ERRO;
                else if (!fim_rodada)
                    proximo = PROXIMA_JOGADA;
                else if (fim_jogo)
                    proximo = FIM_ACERTO;
                else
                    proximo = PROXIMA_ESCRITA;
            end
            PROXIMA_JOGADA:   proximo = ESPERA_JOGADA;
            PROXIMA_ESCRITA:  proximo = ESPERA_ESCRITA;
            ESPERA_ESCRITA: begin
                if (jogada_feita)
                    proximo = REGISTRA_ESCRITA;
                else if (expirou)
                    proximo = FIM_TIMEOUT;
                else
                    proximo = ESPERA_ESCRITA;
            end
            REGISTRA_ESCRITA: proximo = ESCREVE;
            ESCREVE:          proximo = PROXIMA_RODADA;
            PROXIMA_RODADA:   proximo = INICIA_RODADA;
            FIM_ACERTO:       proximo = iniciar ? PREPARA : FIM_ACERTO;
            FIM_ERRO:         proximo = iniciar ? PREPARA : FIM_ERRO;
            FIM_TIMEOUT:      proximo = iniciar ? PREPARA : FIM_TIMEOUT;
            default:          proximo = INICIAL;
        endcase
    end

    always_comb begin
        zera_jogada  = 1'b0;
        conta_jogada = 1'b0;
        zera_rodada  = 1'b0;
        conta_rodada = 1'b0;
        zeraR        = 1'b0;
        registraR    = 1'b0;
        zeraInativo  = 1'b0;
        contaInativo = 1'b0;
        ramWE        = 1'b0;
        pronto       = 1'b0;
        ganhou       = 1'b0;
        errou        = 1'b0;
        timeout      = 1'b0;
        case (estado)
            PREPARA: begin
                zera_jogada = 1'b1;
                zera_rodada = 1'b1;
                zeraR       = 1'b1;
                zeraInativo = 1'b1;
            end
            INICIA_RODADA: begin
                zera_jogada = 1'b1;
                zeraInativo = 1'b1;
            end
            ESPERA_JOGADA:    contaInativo = 1'b1;
            REGISTRA: begin
                registraR   = 1'b1;
                zeraInativo = 1'b1;
            end
            PROXIMA_JOGADA:   conta_jogada = 1'b1;
            PROXIMA_ESCRITA: begin
                conta_jogada = 1'b1;
                zeraInativo  = 1'b1;
            end
            ESPERA_ESCRITA:   contaInativo = 1'b1;
            REGISTRA_ESCRITA: begin
                registraR   = 1'b1;
                zeraInativo = 1'b1;
            end
            ESCREVE:          ramWE = 1'b1;
            PROXIMA_RODADA:   conta_rodada = 1'b1;
            FIM_ACERTO: begin
                pronto = 1'b1;
                ganhou = 1'b1;
            end
            FIM_ERRO: begin
                pronto = 1'b1;
                errou  = 1'b1;
            end
            FIM_TIMEOUT: begin
                pronto  = 1'b1;
                timeout = 1'b1;
            end
            default: ;
        endcase
    end

    assign db_estado = estado;

endmodule

// File: tb/tb_unidade_controle.sv
// Scoreboard bench for unidade_controle: driver queues the expected
// state per edge, a monitor pops and compares after each rising edge.
module tb_unidade_controle;
    import unidade_controle_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic iniciar = 1'b0;
    logic jogada_feita = 1'b0;
    logic jogada_igual = 1'b0;
    logic fim_rodada = 1'b0;
    logic fim_jogo = 1'b0;
    logic inativo = 1'b0;

    logic zj, cj, zr, cr, zR, rR, zI, cI, we, pr, ga, er, to;
    logic zj0, cj0, zr0, cr0, zR0, rR0, zI0, cI0, we0, pr0, ga0, er0, to0;
    logic [ESTADO_W-1:0] est, est0;

    unidade_controle #(.TIMEOUT_EN(1'b1)) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar),
        .jogada_feita(jogada_feita), .jogada_igual(jogada_igual),
        .fim_rodada(fim_rodada), .fim_jogo(fim_jogo), .inativo(inativo),
        .zera_jogada(zj), .conta_jogada(cj), .zera_rodada(zr),
        .conta_rodada(cr), .zeraR(zR), .registraR(rR),
        .zeraInativo(zI), .contaInativo(cI), .ramWE(we),
        .pronto(pr), .ganhou(ga), .errou(er), .timeout(to),
        .db_estado(est)
    );

    unidade_controle #(.TIMEOUT_EN(1'b0)) dut0 (
        .clock(clock), .reset(reset), .iniciar(iniciar),
        .jogada_feita(jogada_feita), .jogada_igual(jogada_igual),
        .fim_rodada(fim_rodada), .fim_jogo(fim_jogo), .inativo(inativo),
        .zera_jogada(zj0), .conta_jogada(cj0), .zera_rodada(zr0),
        .conta_rodada(cr0), .zeraR(zR0), .registraR(rR0),
        .zeraInativo(zI0), .contaInativo(cI0), .ramWE(we0),
        .pronto(pr0), .ganhou(ga0), .errou(er0), .timeout(to0),
        .db_estado(est0)
    );

    always #5 clock = ~clock;

    logic [12:0] outs, outs0;
    assign outs  = {zj, cj, zr, cr, zR, rR, zI, cI, we, pr, ga, er, to};
    assign outs0 = {zj0, cj0, zr0, cr0, zR0, rR0, zI0, cI0,
                    we0, pr0, ga0, er0, to0};

    localparam logic [12:0] ZJ = 13'h1000, CJ = 13'h0800, ZRO = 13'h0400;
    localparam logic [12:0] CR = 13'h0200, ZRG = 13'h0100, RRG = 13'h0080;
    localparam logic [12:0] ZI = 13'h0040, CI = 13'h0020, WE = 13'h0010;
    localparam logic [12:0] PR = 13'h0008, GA = 13'h0004, ER = 13'h0002;
    localparam logic [12:0] TO = 13'h0001;

    // Expected strobes per state, written from the state table.
    function automatic logic [12:0] exp_outs(input logic [3:0] s);
        case (s)
            4'h1: return ZJ | ZRO | ZRG | ZI;
            4'h2: return ZJ | ZI;
            4'h3: return CI;
            4'h4: return RRG | ZI;
            4'h6: return CJ;
            4'h7: return CJ | ZI;
            4'h8: return CI;
            4'h9: return RRG | ZI;
            4'hA: return WE;
            4'hB: return CR;
            4'hC: return PR | GA;
            4'hD: return PR | ER;
            4'hE: return PR | TO;
            default: return 13'h0000;
        endcase
    endfunction

    typedef struct {
        logic [3:0] st;
        logic [3:0] st0;
    } exp_t;

    exp_t q[$];
    int   nerr = 0;
    int   nchk = 0;
    int   nwe = 0;
    int   ncr = 0;
    bit   counting = 1'b0;

    task automatic chk(input string name, input logic [15:0] act,
                       input logic [15:0] req);
        nchk++;
        if (act !== req) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    always @(posedge clock) begin
        exp_t e;
        #1;
        if (counting) begin
            if (we) nwe++;
            if (cr) ncr++;
        end
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("estado", {12'h0, est}, {12'h0, e.st});
            chk("saidas", {3'h0, outs}, {3'h0, exp_outs(e.st)});
            chk("estado_sem_timeout", {12'h0, est0}, {12'h0, e.st0});
            chk("um_fim", {15'h0, (ga + er + to == 2'd1) == pr},
                16'h0001);
        end
    end

    task automatic step(input logic [3:0] es, input int es0 = -1,
                        input bit jf = 0, input bit ji = 0,
                        input bit fr = 0, input bit fj = 0,
                        input bit ina = 0, input bit ini = 0);
        exp_t e;
        @(negedge clock);
        jogada_feita = jf;
        jogada_igual = ji;
        fim_rodada   = fr;
        fim_jogo     = fj;
        inativo      = ina;
        iniciar      = ini;
        e.st  = es;
        e.st0 = (es0 < 0) ? es : es0[3:0];
        q.push_back(e);
        @(posedge clock);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic go_espera_escrita();
        step(PREPARA, -1, 0, 0, 0, 0, 0, 1);
        step(INICIA_RODADA);
        step(ESPERA_JOGADA);
        step(REGISTRA, -1, 1);
        step(COMPARA);
        step(PROXIMA_ESCRITA, -1, 0, 1, 1);
        step(ESPERA_ESCRITA);
    endtask

    initial begin
        repeat (2) @(posedge clock);
        #1;
        chk("reset_estado", {12'h0, est}, 16'h0);
        chk("reset_saidas", {3'h0, outs}, 16'h0);
        do_reset();
        step(INICIAL);

        // asynchronous reset in ESPERA_ESCRITA
        go_espera_escrita();
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("reset_async_estado", {12'h0, est}, 16'h0);
        chk("reset_async_saidas", {3'h0, outs}, 16'h0);
        @(negedge clock);
        reset = 1'b0;
        step(PREPARA, -1, 0, 0, 0, 0, 0, 1);
        step(INICIA_RODADA);

        // round 0 success through the write
        step(ESPERA_JOGADA);
        step(REGISTRA, -1, 1);
        step(COMPARA);
        step(PROXIMA_ESCRITA, -1, 0, 1, 1);
        step(ESPERA_ESCRITA);
        step(REGISTRA_ESCRITA, -1, 1);
        step(ESCREVE);
        step(PROXIMA_RODADA);
        step(INICIA_RODADA);

        // mismatch, iniciar ignored mid-round, then restart
        step(ESPERA_JOGADA, -1, 0, 0, 0, 0, 0, 1);
        step(REGISTRA, -1, 1);
        step(COMPARA);
        step(FIM_ERRO, -1, 0, 0, 1);
        step(FIM_ERRO);
        step(PREPARA, -1, 0, 0, 0, 0, 0, 1);
        step(INICIA_RODADA);

        // timeout, and the same input on the TIMEOUT_EN=0 instance
        step(ESPERA_JOGADA);
        step(FIM_TIMEOUT, ESPERA_JOGADA, 0, 0, 0, 0, 1);
        step(FIM_TIMEOUT, ESPERA_JOGADA, 0, 0, 0, 0, 1);
        do_reset();

        // jogada_feita beats inativo
        go_espera_escrita();
        step(REGISTRA_ESCRITA, -1, 1, 0, 0, 0, 1);
        step(ESCREVE);
        step(PROXIMA_RODADA);
        step(INICIA_RODADA);
        do_reset();

        // full 16-round game
        counting = 1'b1;
        step(PREPARA, -1, 0, 0, 0, 0, 0, 1);
        step(INICIA_RODADA);
        for (int r = 0; r < 16; r++) begin
            step(ESPERA_JOGADA);
            for (int k = 0; k <= r; k++) begin
                step(REGISTRA, -1, 1);
                step(COMPARA);
                if (k < r) begin
                    step(PROXIMA_JOGADA, -1, 0, 1, 0);
                    step(ESPERA_JOGADA);
                end else if (r < 15) begin
                    step(PROXIMA_ESCRITA, -1, 0, 1, 1);
                    step(ESPERA_ESCRITA);
                    step(REGISTRA_ESCRITA, -1, 1);
                    step(ESCREVE);
                    step(PROXIMA_RODADA);
                    step(INICIA_RODADA);
                end else begin
                    step(FIM_ACERTO, -1, 0, 1, 1, 1);
                end
            end
        end
        step(FIM_ACERTO);
        @(posedge clock);
        #2;
        counting = 1'b0;
        chk("pulsos_ramWE", nwe[15:0], 16'd15);
        chk("pulsos_conta_rodada", ncr[15:0], 16'd15);
        chk("fila_vazia", q.size(), 16'd0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
